// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle shared by N_REQ requesters, the write arbiter and the downstream FIFO.
// The arbiter takes the slave view; requesters and the FIFO together take the master view.
interface fifo_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ*WIDTH-1:0] i_data;
  logic [N_REQ-1:0]       i_valid;
  logic [N_REQ-1:0]       o_ready;
  logic [WIDTH-1:0]       o_data;
  logic                   o_valid;
  logic                   i_ready;
  logic [ID_W-1:0]        o_id;

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_id
  );

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_id
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter with burst locking feeding one registered beat per cycle into a
// shared valid/ready FIFO write port; o_data/o_valid/o_id are flop outputs.
module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cg,
  fifo_write_arbiter_if.slave  bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef logic [ID_W-1:0]  id_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_e;

  lock_state_e      state_q, state_d;
  id_t              rr_ptr_q, rr_ptr_d;
  id_t              owner_q, owner_d;
  cnt_t             burst_cnt_q, burst_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  id_t              out_id_q, out_id_d;

  logic can_accept;
  logic lock_hit;
  logic grant_any;
  logic accept;
  id_t  grant_idx;

  // The output register can take a beat when it is empty or being drained this cycle.
  assign can_accept = i_cg & (~out_valid_q | bus.i_ready);
  assign accept     = grant_any & can_accept;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path leaves it
    // unassigned; a missing default infers a latch.
    id_t idx;
    idx       = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    lock_hit  = (state_q == ST_LOCKED) && bus.i_valid[owner_q];
    if (lock_hit) begin
      grant_idx = owner_q;
      grant_any = 1'b1;
    end else begin
      // Scan from the farthest slot back to rr_ptr+1 so the nearest valid requester wins.
      for (int off = N_REQ; off >= 1; off--) begin
        idx = id_t'((int'(rr_ptr_q) + off) % N_REQ);
        if (bus.i_valid[idx]) begin
          grant_idx = idx;
          grant_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.o_ready = '0;
    if (accept) begin
      bus.o_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;

    if (i_cg) begin
      if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = bus.i_data[grant_idx*WIDTH +: WIDTH];
        out_id_d    = grant_idx;
      end else if (out_valid_q && bus.i_ready) begin
        out_valid_d = 1'b0;
      end

      // An owner that drops valid gives up the lock; the same cycle already arbitrates round-robin.
      if (state_q == ST_LOCKED && !lock_hit) begin
        state_d     = ST_OPEN;
        burst_cnt_d = '0;
        rr_ptr_d    = owner_q;
      end

      if (accept) begin
        if (lock_hit) begin
          if (burst_cnt_q == cnt_t'(MAX_BURST - 1)) begin
            state_d     = ST_OPEN;
            burst_cnt_d = '0;
            rr_ptr_d    = grant_idx;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else begin
          rr_ptr_d = grant_idx;
          if (MAX_BURST > 1) begin
            state_d     = ST_LOCKED;
            owner_d     = grant_idx;
            burst_cnt_d = cnt_t'(1);
          end
        end
      end
    end
  end

  // Reset points rr_ptr at the last requester so requester 0 wins the first arbitration.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (i_rst) begin
      state_q     <= ST_OPEN;
      rr_ptr_q    <= id_t'(N_REQ - 1);
      owner_q     <= '0;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign bus.o_valid = out_valid_q;
  assign bus.o_data  = out_data_q;
  assign bus.o_id    = out_id_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: directed arbitration/lock/stall/clockgate/reset scenarios on a
// MAX_BURST=4 instance, then random traffic on MAX_BURST=4 and MAX_BURST=1 instances together.
module tb_fifo_write_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cg  = 1'b1;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus0 ();
  fifo_write_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus1 ();

  fifo_write_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(4)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .bus(bus0.slave)
  );
  fifo_write_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .bus(bus1.slave)
  );

  logic [N-1:0] o_rdy [2];
  logic         o_vld [2];
  logic [W-1:0] o_dat [2];
  logic [1:0]   o_idv [2];
  assign o_rdy[0] = bus0.o_ready;
  assign o_rdy[1] = bus1.o_ready;
  assign o_vld[0] = bus0.o_valid;
  assign o_vld[1] = bus1.o_valid;
  assign o_dat[0] = bus0.o_data;
  assign o_dat[1] = bus1.o_data;
  assign o_idv[0] = bus0.o_id;
  assign o_idv[1] = bus1.o_id;

  // Requester/FIFO-side stimulus state, one set per instance.
  logic [N-1:0] vld [2];
  logic         rdy_in [2];
  int           seq [2][N];
  logic [N-1:0] last_acc [2];
  int           wait_cnt [2][N];
  int           outst [2];
  logic [W-1:0] sbq [2][N][$];
  int           exp_id [$];
  logic         id_chk = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] dat(int d, int k);
    return W'((k << 6) | (seq[d][k] & 63));
  endfunction

  function automatic int burst_of(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic drive();
    bus0.i_valid = vld[0];
    bus0.i_ready = rdy_in[0];
    bus1.i_valid = vld[1];
    bus1.i_ready = rdy_in[1];
    for (int k = 0; k < N; k++) begin
      bus0.i_data[k*W +: W] = dat(0, k);
      bus1.i_data[k*W +: W] = dat(1, k);
    end
  endtask

  // One clock: drive at the negedge, sample handshakes just after, check outputs at the next negedge.
  task automatic tick(input logic chk, input logic [N-1:0] exp_rdy);
    logic         pv [2];
    logic [W-1:0] pd [2];
    logic [1:0]   pid [2];
    int           kidx [2];
    logic         cgv;
    drive();
    #1;
    cgv = cg;
    if (chk) check("o_ready", 32'(o_rdy[0]), 32'(exp_rdy));
    for (int d = 0; d < 2; d++) begin
      last_acc[d] = vld[d] & o_rdy[d];
      check("ready_onehot_within_valid",
            32'($onehot0(o_rdy[d]) && ((o_rdy[d] & ~vld[d]) == '0)), 32'd1);
      pv[d]   = o_vld[d];
      pd[d]   = o_dat[d];
      pid[d]  = o_idv[d];
      kidx[d] = -1;
      if (cgv && pv[d] && rdy_in[d]) outst[d]--;
      for (int k = 0; k < N; k++) begin
        if (last_acc[d][k]) begin
          kidx[d] = k;
          outst[d]++;
          sbq[d][k].push_back(dat(d, k));
          seq[d][k]++;
          check("fairness_wait", 32'(wait_cnt[d][k] <= (N - 1) * burst_of(d)), 32'd1);
          wait_cnt[d][k] = 0;
        end else if (vld[d][k] && last_acc[d] != '0) begin
          wait_cnt[d][k]++;
        end else if (!vld[d][k]) begin
          wait_cnt[d][k] = 0;
        end
      end
      if (d == 0 && id_chk && kidx[0] >= 0) begin
        if (exp_id.size() == 0) check("id_extra", 32'(kidx[0]), 32'd99);
        else check("id_order", 32'(kidx[0]), 32'(exp_id.pop_front()));
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (kidx[d] >= 0) begin
        check("valid_after_accept", 32'(o_vld[d]), 32'd1);
        check("id_after_accept", 32'(o_idv[d]), 32'(kidx[d]));
        check("sb_depth", 32'(sbq[d][o_idv[d]].size()), 32'd1);
        if (sbq[d][o_idv[d]].size() != 0)
          check("sb_data", 32'(o_dat[d]), 32'(sbq[d][o_idv[d]].pop_front()));
      end else begin
        check("valid_next", 32'(o_vld[d]), (cgv && pv[d] && rdy_in[d]) ? 32'd0 : 32'(pv[d]));
        check("data_hold", 32'(o_dat[d]), 32'(pd[d]));
        check("id_hold", 32'(o_idv[d]), 32'(pid[d]));
      end
    end
  endtask

  // Asserted mid-cycle (at a negedge); outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", 32'(o_vld[d]), 32'd0);
      check("rst_data", 32'(o_dat[d]), 32'd0);
      check("rst_id", 32'(o_idv[d]), 32'd0);
      outst[d]    = 0;
      last_acc[d] = '0;
      for (int k = 0; k < N; k++) begin
        sbq[d][k].delete();
        wait_cnt[d][k] = 0;
      end
    end
    exp_id.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_ids(input int id, input int count);
    for (int i = 0; i < count; i++) exp_id.push_back(id);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      vld[d]    = '0;
      rdy_in[d] = 1'b1;
      outst[d]  = 0;
      for (int k = 0; k < N; k++) begin
        seq[d][k]      = 0;
        wait_cnt[d][k] = 0;
      end
    end
    drive();
    @(negedge clk);
    do_reset();

    // All requesters valid: bursts of four rotating 0,1,2,3,0.
    vld[0] = 4'b1111;
    id_chk = 1'b1;
    for (int i = 0; i < 20; i++) exp_id.push_back((i / 4) % 4);
    repeat (20) tick(1'b0, '0);
    check("id_done_rotation", 32'(exp_id.size()), 32'd0);

    // Single requester: ready every cycle, across burst boundaries.
    vld[0] = 4'b0100;
    push_ids(2, 10);
    repeat (10) tick(1'b1, 4'b0100);
    vld[0] = 4'b0000;
    repeat (2) tick(1'b0, '0);
    check("id_done_single", 32'(exp_id.size()), 32'd0);

    // Owner drops after two beats: req1 wins in the drop cycle, then req3.
    do_reset();
    vld[0] = 4'b1011;
    push_ids(0, 2);
    repeat (2) tick(1'b0, '0);
    vld[0] = 4'b1010;
    push_ids(1, 4);
    push_ids(3, 2);
    tick(1'b1, 4'b0010);
    repeat (5) tick(1'b0, '0);
    check("id_done_drop", 32'(exp_id.size()), 32'd0);
    vld[0] = 4'b0000;
    repeat (2) tick(1'b0, '0);

    // Backpressure: one beat captured, then a stall; the burst resumes at count 2.
    do_reset();
    vld[0]    = 4'b1111;
    rdy_in[0] = 1'b0;
    push_ids(0, 1);
    tick(1'b1, 4'b0001);
    repeat (9) tick(1'b1, 4'b0000);
    rdy_in[0] = 1'b1;
    push_ids(0, 3);
    push_ids(1, 2);
    repeat (5) tick(1'b0, '0);

    // Clockgate low mid-burst freezes everything; the burst then continues unchanged.
    cg = 1'b0;
    repeat (5) tick(1'b1, 4'b0000);
    cg = 1'b1;
    push_ids(1, 2);
    push_ids(2, 4);
    push_ids(3, 2);
    repeat (8) tick(1'b0, '0);
    check("id_done_cg", 32'(exp_id.size()), 32'd0);

    // Async reset mid-burst of req3: next grant goes to req0.
    do_reset();
    push_ids(0, 1);
    tick(1'b1, 4'b0001);
    check("id_done_reset", 32'(exp_id.size()), 32'd0);
    vld[0] = 4'b0000;
    id_chk = 1'b0;
    repeat (3) tick(1'b0, '0);

    // Random traffic on both instances; requesters only drop valid after an accept.
    for (int c = 0; c < 15000; c++) begin
      cg = ($urandom_range(0, 9) != 0);
      for (int d = 0; d < 2; d++) begin
        rdy_in[d] = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < N; k++) begin
          if (last_acc[d][k]) vld[d][k] = 1'($urandom_range(0, 1));
          else if (!vld[d][k]) vld[d][k] = ($urandom_range(0, 2) != 0);
        end
      end
      tick(1'b0, '0);
    end

    cg = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vld[d]    = '0;
      rdy_in[d] = 1'b1;
    end
    repeat (3) tick(1'b0, '0);
    for (int d = 0; d < 2; d++) begin
      check("drain_valid", 32'(o_vld[d]), 32'd0);
      check("drain_outstanding", 32'(outst[d]), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter sharing the write port of one valid/ready datapath (fifoW1R1, cdcFifo or cdcData write side) between N_REQ requesters.
- Supports burst locking: a granted requester keeps the port for up to MAX_BURST consecutive beats.
- Has a single registered output stage, so o_data/o_valid are flop outputs.
- Sits directly upstream of the shared FIFO's i_data/i_valid/o_ready.

Parameters:
- N_REQ, 4, number of requesters; >=2.
- WIDTH, 8, data width per beat.
- MAX_BURST, 4, max consecutive beats per grant; >=1. A value of 1 gives pure per-beat round-robin.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_cg  input  1  clockgate enable; low freezes all state.
- i_data  input  N_REQ*WIDTH  requester k data in bits [k*WIDTH +: WIDTH].
- i_valid  input  N_REQ  per-requester valid.
- o_ready  output  N_REQ  per-requester ready (combinational).
- o_data  output  WIDTH  registered beat to the FIFO.
- o_valid  output  1  registered valid to the FIFO.
- i_ready  input  1  FIFO ready (o_wready of the FIFO).
- o_id  output  $clog2(N_REQ)  requester index of the beat held in o_data.

Behaviour:
- Reset (async, immediate):
  - o_valid=0, o_data=0, o_id=0.
  - rrPtr=N_REQ-1, so requester 0 has top priority after reset.
  - locked=0, lockOwner=0, burstCnt=0.
- Internal state:
  - rrPtr: last-granted index.
  - locked, lockOwner, burstCnt: width $clog2(MAX_BURST+1).
- canAccept = i_cg & (!o_valid | i_ready).
- Grant (combinational, one-hot or zero):
  - If locked & i_valid[lockOwner], grant lockOwner.
  - Otherwise grant the first k with i_valid[k], searching rrPtr+1, rrPtr+2, ... modulo N_REQ.
  - If no requester is valid, there is no grant.
- o_ready[k] = grant[k] & canAccept.
- Never more than one o_ready bit is high.
- o_ready does not depend on i_valid of other requesters once a lock is held.
- Accept of requester k (i_valid[k] & o_ready[k]):
  - Next edge: o_data=i_data[k], o_id=k, o_valid=1. Latency is 1 cycle.
  - Zero-bubble throughput when i_ready is held high.
- Lock update on an accept by the locked owner:
  - burstCnt += 1.
  - If burstCnt+1 == MAX_BURST: locked=0, burstCnt=0, rrPtr=k.
- Lock update on an accept from a fresh (unlocked) grant:
  - rrPtr=k.
  - If MAX_BURST>1: locked=1, lockOwner=k, burstCnt=1.
  - Else locked stays 0.
- Lock release on drop:
  - A locked owner with i_valid low in any cycle with i_cg=1 releases the lock: locked=0, burstCnt=0, rrPtr=lockOwner.
  - Arbitration that same cycle already falls through to round-robin.
- Drain:
  - i_cg & o_valid & i_ready with no new accept: o_valid=0 at the next edge.
  - o_data and o_id hold their last value.
- Backpressure:
  - o_valid & !i_ready gives canAccept=0.
  - All o_ready are 0; o_data, o_id, o_valid and lock state are stable.
  - A stalled grant does not count toward burstCnt.
- i_cg=0:
  - No state changes and o_ready=0.
  - Outputs hold; i_ready is ignored.
- Requesters must not drop i_valid or change i_data while o_ready is low and they were previously valid. Violations only affect arbitration order, never data integrity.
- Reset mid-burst discards the held beat; the lost beat is the requester's responsibility.

Test Plan:
- All i_valid=4'b1111, i_ready=1, i_cg=1, MAX_BURST=4 -> o_id sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...; o_valid continuous from the 2nd cycle after reset release.
- Only i_valid[2]=1, i_ready=1 -> o_ready[2] high every cycle, including at burst boundaries; o_id=2 and o_valid continuously 1 with no bubbles.
- req0 sends 2 beats then drops, req1 and req3 valid -> req1 granted in the drop cycle, then 4 beats of req1, then req3; no req0 beat is lost or duplicated.
- i_ready=0 for 10 cycles while all are valid -> exactly one beat captured, o_ready=4'b0000, o_data/o_id stable; on i_ready=1, next beat arrives from the same lock owner and burstCnt continues at 2.
- i_cg=0 for 5 cycles mid-burst -> o_ready=0, outputs and burstCnt frozen; burst resumes unchanged afterwards. Assert i_rst asynchronously mid-cycle -> o_valid drops before the next edge and the next grant goes to requester 0.
- Random valid/ready/cg with 10k beats, MAX_BURST=1 and 4 -> scoreboard per-o_id data matches per-requester send order. No requester waits more than (N_REQ-1)*MAX_BURST accepted beats while continuously valid.
